// File: rtl/multicycle_adder.sv
// multicycle_adder: sequential add/subtract unit that handles WIDTH-bit
// operands one CHUNK-bit slice per clock and passes the carry from each slice
// to the next. Operands are taken on in_valid & in_ready. The result is held
// until out_valid & out_ready.
// Optional feature: define MULTICYCLE_ADDER_OVERFLOW_EN to add the 'overflow'
// output (signed two's-complement overflow of the final result).
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             zero
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // A slice width that does not divide the operand width cannot be built.
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("multicycle_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [CHUNK:0]    slice_res;
    logic [WIDTH-1:0]  sum_next;
    logic              last_slice;

    assign last_slice = (idx == IDXW'(NSLICE - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, step through slices, then hold the result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs depend only on state, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // One slice of the add: the low CHUNK bits of the shifted operands plus the chained carry.
    always_comb begin
        slice_res = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry};
    end

    // Merge the fresh slice into the result at the position selected by idx.
    always_comb begin
        sum_next = sum;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDXW'(i)) begin
                sum_next[i*CHUNK +: CHUNK] = slice_res[CHUNK-1:0];
            end
        end
    end

    // Datapath: latch operands on accept (B inverted for subtract), then ripple one slice per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b1;
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b ^ {WIDTH{sub}};
                        carry <= sub | carry_in;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum   <= sum_next;
                    carry <= slice_res[CHUNK];
                    a_reg <= a_reg >> CHUNK;
                    b_reg <= b_reg >> CHUNK;
                    idx   <= idx + IDXW'(1);
                    if (last_slice) begin
                        carry_out <= slice_res[CHUNK];
                        zero      <= (sum_next == '0);
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
                        overflow  <= slice_res[CHUNK]
                                   ^ (a_reg[CHUNK-1] ^ b_reg[CHUNK-1] ^ slice_res[CHUNK-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: directed tests for multicycle_adder. The main instance
// uses CHUNK=8. Two more instances (CHUNK=1 and CHUNK=32) check latency and
// results on random operands.
module tb_multicycle_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [31:0] a, b;
    logic        sub, carry_in;
    logic        in_ready, out_valid, carry_out, zero;
    logic [31:0] sum;

    logic        v_in_valid, v_out_ready;
    logic        c1_in_ready, c1_out_valid, c1_carry_out, c1_zero;
    logic [31:0] c1_sum;
    logic        c32_in_ready, c32_out_valid, c32_carry_out, c32_zero;
    logic [31:0] c32_sum;
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
    logic        overflow, c1_overflow, c32_overflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .zero(zero)
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
        , .overflow(overflow)
`endif
    );

    multicycle_adder #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(c1_in_ready),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .out_valid(c1_out_valid), .out_ready(v_out_ready),
        .sum(c1_sum), .carry_out(c1_carry_out), .zero(c1_zero)
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
        , .overflow(c1_overflow)
`endif
    );

    multicycle_adder #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(c32_in_ready),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .out_valid(c32_out_valid), .out_ready(v_out_ready),
        .sum(c32_sum), .carry_out(c32_carry_out), .zero(c32_zero)
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
        , .overflow(c32_overflow)
`endif
    );

    // Start one operation on the main instance, scramble its inputs after the
    // accept edge, and count the clocks until out_valid (-1 means timeout).
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input logic tc, output int lat);
        a = ta; b = tb_v; sub = ts; carry_in = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ta; b = ~tb_v; sub = ~ts; carry_in = ~tc;
        lat = -1;
        for (int i = 1; i <= 100 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (out_valid) lat = i;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; v_in_valid = 1'b0; v_out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; carry_in = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("[TB] FAIL reset_sum got %h want 0", sum); end
        checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL reset_zero got %0b want 1", zero); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_carry_out got %0b want 0", carry_out); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_out_valid got %0b want 0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("[TB] FAIL post_reset_sum got %h want 0", sum); end
        checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_zero got %0b want 1", zero); end
    endtask

    task automatic test_carry_ripple();
        int lat;
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
        checks++; if (lat != 4) begin errors++; $display("[TB] FAIL ripple_latency got %0d want 4", lat); end
        checks++; if (sum !== 32'h0) begin errors++; $display("[TB] FAIL ripple_sum got %h want 0", sum); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("[TB] FAIL ripple_carry_out got %0b want 1", carry_out); end
        checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL ripple_zero got %0b want 1", zero); end
        release_result();
    endtask

    task automatic test_add_sub();
        logic [31:0] va [5]  = '{32'd5, 32'd7, 32'd10, 32'd100, 32'd0};
        logic [31:0] vb [5]  = '{32'd7, 32'd5, 32'd3, 32'd200, 32'd0};
        logic        vs [5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        vc [5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] es [5]  = '{32'hFFFF_FFFE, 32'd2, 32'd7, 32'd301, 32'd0};
        logic        eco [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        ez [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int k = 0; k < 5; k++) begin
            run_op(va[k], vb[k], vs[k], vc[k], lat);
            checks++; if (sum !== es[k]) begin errors++; $display("[TB] FAIL addsub_sum[%0d] got %h want %h", k, sum, es[k]); end
            checks++; if (carry_out !== eco[k]) begin errors++; $display("[TB] FAIL addsub_carry_out[%0d] got %0b want %0b", k, carry_out, eco[k]); end
            checks++; if (zero !== ez[k]) begin errors++; $display("[TB] FAIL addsub_zero[%0d] got %0b want %0b", k, zero, ez[k]); end
            release_result();
        end
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_pos got %0b want 1", overflow); end
        checks++; if (sum !== 32'h8000_0000) begin errors++; $display("[TB] FAIL overflow_sum got %h want 80000000", sum); end
        release_result();
        run_op(32'd5, 32'd7, 1'b1, 1'b0, lat);
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL overflow_none got %0b want 0", overflow); end
        release_result();
`endif
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
        checks++; if (lat != 4) begin errors++; $display("[TB] FAIL bp_latency got %0d want 4", lat); end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin a = 32'h0; b = 32'h0; in_valid = 1'b1; end
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++; if (sum !== 32'h2345_6789) begin errors++; $display("[TB] FAIL bp_sum_stable[%0d] got %h want 23456789", k, sum); end
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_handshake[%0d] got ov=%0b ir=%0b want ov=1 ir=0", k, out_valid, in_ready); end
        end
        release_result();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got ov=%0b ir=%0b want ov=0 ir=1", out_valid, in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_not_queued got ir=%0b want 1", in_ready); end
    endtask

    task automatic test_abort();
        int  lat;
        bit  seen = 0;
        a = 32'h0F0F_0F0F; b = 32'h0101_0101; sub = 1'b0; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (sum !== 32'h0) begin errors++; $display("[TB] FAIL abort_sum got %h want 0", sum); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_state got ov=%0b ir=%0b want ov=0 ir=1", out_valid, in_ready); end
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("[TB] FAIL abort_no_valid got out_valid=1 want 0"); end
        run_op(32'd10, 32'd20, 1'b0, 1'b0, lat);
        checks++; if (lat != 4) begin errors++; $display("[TB] FAIL abort_next_latency got %0d want 4", lat); end
        checks++; if (sum !== 32'd30) begin errors++; $display("[TB] FAIL abort_next_sum got %0d want 30", sum); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(32'd1, 32'd2, 1'b0, 1'b0, lat);
        checks++; if (sum !== 32'd3) begin errors++; $display("[TB] FAIL b2b_first_sum got %0d want 3", sum); end
        out_ready = 1'b1; in_valid = 1'b1; a = 32'd100; b = 32'd23; sub = 1'b0; carry_in = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got ir=%0b ov=%0b want ir=1 ov=0", in_ready, out_valid); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept got ir=%0b want 0", in_ready); end
        in_valid = 1'b0; out_ready = 1'b0; a = 32'h0; b = 32'h0;
        lat = -1;
        for (int i = 1; i <= 100 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (out_valid) lat = i;
        end
        checks++; if (lat != 4) begin errors++; $display("[TB] FAIL b2b_latency got %0d want 4", lat); end
        checks++; if (sum !== 32'd123) begin errors++; $display("[TB] FAIL b2b_second_sum got %0d want 123", sum); end
        release_result();
    endtask

    task automatic test_chunk_variants();
        logic [31:0] ra, rb;
        logic        rs, rc;
        logic [32:0] expv;
        int          lat1, lat32;
        for (int k = 0; k < 12; k++) begin
            ra = $urandom; rb = $urandom;
            rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            if (k == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h1; rs = 1'b0; rc = 1'b0; end
            expv = rs ? ({1'b0, ra} + {1'b0, ~rb} + 33'd1) : ({1'b0, ra} + {1'b0, rb} + {32'd0, rc});
            a = ra; b = rb; sub = rs; carry_in = rc; v_in_valid = 1'b1;
            @(posedge clk); #1;
            v_in_valid = 1'b0;
            lat1 = -1; lat32 = -1;
            for (int i = 1; i <= 40 && (lat1 < 0 || lat32 < 0); i++) begin
                @(posedge clk); #1;
                if (lat1 < 0 && c1_out_valid) lat1 = i;
                if (lat32 < 0 && c32_out_valid) lat32 = i;
            end
            checks++; if (lat1 != 32) begin errors++; $display("[TB] FAIL c1_latency[%0d] got %0d want 32", k, lat1); end
            checks++; if (lat32 != 1) begin errors++; $display("[TB] FAIL c32_latency[%0d] got %0d want 1", k, lat32); end
            checks++; if ({c1_carry_out, c1_sum} !== expv) begin errors++; $display("[TB] FAIL c1_result[%0d] got %h want %h", k, {c1_carry_out, c1_sum}, expv); end
            checks++; if ({c32_carry_out, c32_sum} !== expv) begin errors++; $display("[TB] FAIL c32_result[%0d] got %h want %h", k, {c32_carry_out, c32_sum}, expv); end
            checks++; if (c1_zero !== (expv[31:0] == 32'h0)) begin errors++; $display("[TB] FAIL c1_zero[%0d] got %0b want %0b", k, c1_zero, (expv[31:0] == 32'h0)); end
            v_out_ready = 1'b1;
            @(posedge clk); #1;
            v_out_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired got timeout want completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_carry_ripple();
        test_add_sub();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_chunk_variants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
